// File: rtl/full_adder_16bit_if.sv
// Operand/result bundle for the registered 16-bit adder.
// The master drives the operands and the slave returns the registered result.
interface full_adder_16bit_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             out_valid;

    modport master (
        output in_valid, a, b, cin,
        input  s, cout, ovf, out_valid
    );

    modport slave (
        input  in_valid, a, b, cin,
        output s, cout, ovf, out_valid
    );
endinterface

// File: rtl/full_adder_16bit.sv
// Registered 16-bit adder: four 4-bit CLA groups joined by a second-level lookahead,
// followed by a single output register.
module full_adder_16bit_cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] sum,
    output logic       gg,
    output logic       gp
);
    logic [3:0] g, p, c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        // Group generate/propagate do not depend on ci, so the second level never waits on a group.
        gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        gp   = &p;
        sum  = p ^ c;
    end
endmodule

module full_adder_16bit #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic                clk,
    input  logic                rst,
    full_adder_16bit_if.slave   bus
);
    localparam int NGRP = WIDTH / GROUP;

    logic [NGRP-1:0]  grp_g;
    logic [NGRP-1:0]  grp_p;
    logic [NGRP:0]    grp_c;
    logic [WIDTH-1:0] sum;
    logic             ovf_nxt;
    logic             term;
    logic             vld_q;

    for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
        full_adder_16bit_cla4 u_cla4 (
            .a   (bus.a[gi*GROUP +: GROUP]),
            .b   (bus.b[gi*GROUP +: GROUP]),
            .ci  (grp_c[gi]),
            .sum (sum[gi*GROUP +: GROUP]),
            .gg  (grp_g[gi]),
            .gp  (grp_p[gi])
        );
    end

    // Each group carry is a flat sum of products over cin and the group G/P terms.
    always_comb begin
        grp_c    = '0;
        term     = 1'b0;
        grp_c[0] = bus.cin;
        for (int i = 1; i <= NGRP; i++) begin
            term = bus.cin;
            for (int k = 0; k < i; k++) term = term & grp_p[k];
            grp_c[i] = term;
            for (int j = 0; j < i; j++) begin
                term = grp_g[j];
                for (int k = j + 1; k < i; k++) term = term & grp_p[k];
                grp_c[i] = grp_c[i] | term;
            end
        end
    end

    assign ovf_nxt = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.s    <= '0;
            bus.cout <= 1'b0;
            bus.ovf  <= 1'b0;
            vld_q    <= 1'b0;
        end else begin
            vld_q <= bus.in_valid;
            if (bus.in_valid) begin
                bus.s    <= sum;
                bus.cout <= grp_c[NGRP];
                bus.ovf  <= ovf_nxt;
            end
        end
    end

    assign bus.out_valid = vld_q;
endmodule

// File: tb/tb_full_adder_16bit.sv
// Randomized and directed check of full_adder_16bit against an integer-arithmetic model.
module tb_full_adder_16bit;
    logic clk = 1'b0;
    logic rst;
    int   vecs   = 0;
    int   misses = 0;

    logic [15:0] m_s;
    logic        m_cout;
    logic        m_ovf;
    logic        m_vld;

    full_adder_16bit_if #(.WIDTH(16)) bus ();

    full_adder_16bit #(.WIDTH(16), .GROUP(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        if (obs !== exp) begin
            misses++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Called at a negedge: drive inputs, advance the model, then compare after the next posedge.
    task automatic apply(input string tag, input logic r, input logic v,
                         input logic [15:0] a, input logic [15:0] b, input logic ci);
        int full;
        int ssum;
        rst          = r;
        bus.in_valid = v;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = ci;
        if (r) begin
            m_s = '0; m_cout = 1'b0; m_ovf = 1'b0; m_vld = 1'b0;
        end else if (v) begin
            full   = int'(a) + int'(b) + int'(ci);
            ssum   = int'($signed(a)) + int'($signed(b)) + int'(ci);
            m_s    = full[15:0];
            m_cout = (full >= 65536);
            m_ovf  = (ssum > 32767) || (ssum < -32768);
            m_vld  = 1'b1;
        end else begin
            m_vld = 1'b0;
        end
        @(negedge clk);
        chk({tag, ".s"},         32'(bus.s),         32'(m_s));
        chk({tag, ".cout"},      32'(bus.cout),      32'(m_cout));
        chk({tag, ".ovf"},       32'(bus.ovf),       32'(m_ovf));
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_vld));
    endtask

    initial begin
        rst = 1'b1; bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;

        apply("rst0", 1, 0, 16'd0, 16'd0, 0);
        apply("rst1", 1, 1, 16'd1234, 16'd4321, 1);
        apply("zero", 0, 1, 16'd0, 16'd0, 0);

        apply("b0", 0, 1, 16'd1060,  16'd11000, 0);
        apply("b1", 0, 1, 16'd12500, 16'd3100,  1);
        apply("b2", 0, 1, 16'd30143, 16'd2200,  0);
        apply("b3", 0, 1, 16'd1140,  16'd21000, 1);

        apply("wrap0", 0, 1, 16'd65505, 16'd31,    0);
        apply("wrap1", 0, 1, 16'd32005, 16'd33533, 0);
        apply("max",   0, 1, 16'd65535, 16'd65535, 1);

        apply("ovf0", 0, 1, 16'd32767, 16'd1,     0);
        apply("ovf1", 0, 1, 16'd32768, 16'd32768, 0);

        apply("prop0", 0, 1, 16'hFFFF, 16'h0000, 1);
        apply("prop1", 0, 1, 16'h00FF, 16'h0001, 0);

        apply("hold0", 0, 0, 16'hA5A5, 16'h5A5A, 1);
        apply("hold1", 0, 0, 16'hFFFF, 16'hFFFF, 1);
        apply("pre",   0, 1, 16'd100,  16'd200,  0);
        apply("rstv",  1, 1, 16'd999,  16'd1,    0);
        apply("post",  0, 1, 16'h7FFF, 16'h8000, 1);

        for (int i = 0; i < 10000; i++) begin
            logic r;
            logic v;
            r = ($urandom_range(0, 127) == 0);
            v = ($urandom_range(0, 7) != 0);
            apply("rnd", r, v, 16'($urandom), 16'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, misses);
        $finish;
    end
endmodule
